// File: rtl/c1541_gcr_write.sv
// Write-path GCR decoder: finds sync, decodes 5-to-4 GCR data blocks ($07) into the track buffer and checks the XOR checksum.
// Latency: the 5th GCR byte of a group produces its first ram_we 2 clk later; the following payload bytes of that group go out one per clk.
// Backpressure: none. The 16-clk minimum byte spacing covers the 4-write burst; a falling ram_ready_i aborts the block instead.
//
// Ports:
//   clk_c1541, reset       drive clock, synchronous active-high reset
//   mtr_i, mode_i          block is active only when the motor is on and mode is write (0)
//   gcr_di_i, byte_stb_i   GCR byte stream from the drive logic, one strobe per byte
//   cur_sector_i           sector of the last header seen by the read side
//   ram_ready_i            track buffer loaded and free
//   ram_addr_o/do_o/we_o   track buffer write port; ram_sector_o is the sector latched at block start
//   blk_done_o, blk_err_o  one-cycle completion pulses (never both high)
//   busy_o                 a block is in progress
module c1541_gcr_write #(
    parameter int SYNC_MIN    = 2,
    parameter int NUM_SECTORS = 21
) (
    input  logic       clk_c1541,
    input  logic       reset,
    input  logic       mtr_i,
    input  logic       mode_i,
    input  logic [7:0] gcr_di_i,
    input  logic       byte_stb_i,
    input  logic [4:0] cur_sector_i,
    input  logic       ram_ready_i,
    output logic [7:0] ram_addr_o,
    output logic [7:0] ram_do_o,
    output logic       ram_we_o,
    output logic [4:0] ram_sector_o,
    output logic       blk_done_o,
    output logic       blk_err_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_DATA, S_CHK, S_TAIL} state_t;

    localparam logic [2:0] SYNC_MIN_W = 3'(SYNC_MIN);
    localparam logic [5:0] NUM_SEC_W  = 6'(NUM_SECTORS);

    state_t          state_q;
    logic [2:0]      ff_cnt_q;
    logic [2:0]      gcnt_q;      // GCR bytes of the current group already received
    logic [31:0]     sr_q;        // first four GCR bytes of the group, oldest in the top byte
    logic [3:0][7:0] dec_q;       // decoded group, dec_q[0] is the first byte
    logic            dec_bad_q;
    logic            dec_vld_q;   // one-cycle flag: dec_q was just loaded
    logic [1:0]      wr_sel_q;    // next byte of dec_q to write (reused as TAIL byte counter)
    logic            wr_act_q;
    logic [7:0]      chk_q;
    logic            chk_ok_q;
    logic [7:0]      ram_addr_q;
    logic [7:0]      ram_do_q;
    logic            ram_we_q;
    logic [4:0]      ram_sector_q;
    logic            blk_done_q;
    logic            blk_err_q;

    // Returns {invalid, nibble}.
    function automatic logic [4:0] gcr_dec(input logic [4:0] q);
        case (q)
            5'h0A: gcr_dec = 5'h00;  5'h0B: gcr_dec = 5'h01;
            5'h12: gcr_dec = 5'h02;  5'h13: gcr_dec = 5'h03;
            5'h0E: gcr_dec = 5'h04;  5'h0F: gcr_dec = 5'h05;
            5'h16: gcr_dec = 5'h06;  5'h17: gcr_dec = 5'h07;
            5'h09: gcr_dec = 5'h08;  5'h19: gcr_dec = 5'h09;
            5'h1A: gcr_dec = 5'h0A;  5'h1B: gcr_dec = 5'h0B;
            5'h0D: gcr_dec = 5'h0C;  5'h1D: gcr_dec = 5'h0D;
            5'h1E: gcr_dec = 5'h0E;  5'h15: gcr_dec = 5'h0F;
            default: gcr_dec = 5'h10;
        endcase
    endfunction

    // The group decodes straight off the 5th byte as it arrives.
    logic [39:0]     full_d;
    logic [7:0][4:0] qd_d;
    logic [3:0][7:0] grp_d;
    logic            grp_bad_d;

    assign full_d = {sr_q, gcr_di_i};

    for (genvar i = 0; i < 8; i++) begin : g_quint
        assign qd_d[i] = gcr_dec(full_d[39-5*i -: 5]);
    end
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign grp_d[b] = {qd_d[2*b][3:0], qd_d[2*b+1][3:0]};
    end
    assign grp_bad_d = qd_d[0][4] | qd_d[1][4] | qd_d[2][4] | qd_d[3][4]
                     | qd_d[4][4] | qd_d[5][4] | qd_d[6][4] | qd_d[7][4];

    // ram_addr_q holds the address of the write on the bus and steps once
    // after every write, so the address of a write issued now accounts for
    // one still on the bus.
    logic [7:0] wr_addr_d;
    logic [7:0] wr_byte_d;
    logic       act_d;

    assign wr_addr_d = ram_addr_q + {7'd0, ram_we_q};
    assign wr_byte_d = dec_vld_q ? dec_q[0] : dec_q[wr_sel_q];
    assign act_d     = ~mode_i & mtr_i;

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ff_cnt_q     <= '0;
            gcnt_q       <= '0;
            sr_q         <= '0;
            dec_q        <= '0;
            dec_bad_q    <= 1'b0;
            dec_vld_q    <= 1'b0;
            wr_sel_q     <= '0;
            wr_act_q     <= 1'b0;
            chk_q        <= '0;
            chk_ok_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_do_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_sector_q <= '0;
            blk_done_q   <= 1'b0;
            blk_err_q    <= 1'b0;
        end else begin
            ram_we_q   <= 1'b0;
            blk_done_q <= 1'b0;
            blk_err_q  <= 1'b0;
            dec_vld_q  <= 1'b0;
            if (ram_we_q) ram_addr_q <= ram_addr_q + 8'd1;

            if (!act_d) begin
                if (state_q == S_DATA) blk_err_q <= 1'b1;
                state_q  <= S_IDLE;
                ff_cnt_q <= '0;
                gcnt_q   <= '0;
                wr_act_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_SYNC;

                    S_SYNC: if (byte_stb_i) begin
                        if (gcr_di_i == 8'hFF) begin
                            if (ff_cnt_q != 3'd7) ff_cnt_q <= ff_cnt_q + 3'd1;
                        end else begin
                            ff_cnt_q <= '0;
                            // First non-sync byte after enough sync starts group 0.
                            if (ff_cnt_q >= SYNC_MIN_W) begin
                                sr_q    <= {sr_q[23:0], gcr_di_i};
                                gcnt_q  <= 3'd1;
                                state_q <= S_ID;
                            end
                        end
                    end

                    S_ID: begin
                        if (dec_vld_q) begin
                            if (dec_bad_q) begin
                                blk_err_q <= 1'b1;
                                state_q   <= S_SYNC;
                            end else if (dec_q[0] != 8'h07) begin
                                state_q <= S_SYNC;      // header or foreign block
                            end else if (!ram_ready_i || {1'b0, cur_sector_i} >= NUM_SEC_W) begin
                                blk_err_q <= 1'b1;
                                state_q   <= S_SYNC;
                            end else begin
                                // Bytes 1..3 of group 0 are payload 0..2.
                                ram_sector_q <= cur_sector_i;
                                ram_addr_q   <= '0;
                                ram_we_q     <= 1'b1;
                                ram_do_q     <= dec_q[1];
                                chk_q        <= dec_q[1];
                                wr_sel_q     <= 2'd2;
                                wr_act_q     <= 1'b1;
                                state_q      <= S_DATA;
                            end
                        end else if (byte_stb_i) begin
                            sr_q <= {sr_q[23:0], gcr_di_i};
                            if (gcnt_q == 3'd4) begin
                                dec_q     <= grp_d;
                                dec_bad_q <= grp_bad_d;
                                dec_vld_q <= 1'b1;
                                gcnt_q    <= '0;
                            end else begin
                                gcnt_q <= gcnt_q + 3'd1;
                            end
                        end
                    end

                    S_DATA: begin
                        if (!ram_ready_i) begin
                            blk_err_q <= 1'b1;
                            state_q   <= S_SYNC;
                            ff_cnt_q  <= '0;
                            gcnt_q    <= '0;
                            wr_act_q  <= 1'b0;
                        end else if (byte_stb_i && gcr_di_i == 8'hFF) begin
                            // Resync mid-block: this $FF is the first of the new sync run.
                            blk_err_q <= 1'b1;
                            state_q   <= S_SYNC;
                            ff_cnt_q  <= 3'd1;
                            gcnt_q    <= '0;
                            wr_act_q  <= 1'b0;
                        end else if (dec_vld_q && dec_bad_q) begin
                            blk_err_q <= 1'b1;
                            state_q   <= S_SYNC;
                            ff_cnt_q  <= '0;
                            wr_act_q  <= 1'b0;
                        end else if (dec_vld_q || wr_act_q) begin
                            ram_we_q <= 1'b1;
                            ram_do_q <= wr_byte_d;
                            chk_q    <= chk_q ^ wr_byte_d;
                            if (wr_addr_d == 8'hFF) begin
                                // Last payload byte is byte 0 of the final group;
                                // byte 1 of that group is the checksum.
                                wr_act_q <= 1'b0;
                                state_q  <= S_CHK;
                            end else if (dec_vld_q) begin
                                wr_sel_q <= 2'd1;
                                wr_act_q <= 1'b1;
                            end else begin
                                wr_sel_q <= wr_sel_q + 2'd1;
                                if (wr_sel_q == 2'd3) wr_act_q <= 1'b0;
                            end
                        end else if (byte_stb_i) begin
                            sr_q <= {sr_q[23:0], gcr_di_i};
                            if (gcnt_q == 3'd4) begin
                                dec_q     <= grp_d;
                                dec_bad_q <= grp_bad_d;
                                dec_vld_q <= 1'b1;
                                gcnt_q    <= '0;
                            end else begin
                                gcnt_q <= gcnt_q + 3'd1;
                            end
                        end
                    end

                    S_CHK: begin
                        chk_ok_q <= (chk_q == dec_q[1]);
                        if (chk_q != dec_q[1]) blk_err_q <= 1'b1;
                        wr_sel_q <= 2'd2;
                        state_q  <= S_TAIL;
                    end

                    // The two off bytes are already in dec_q; step past them unchecked.
                    S_TAIL: begin
                        if (wr_sel_q == 2'd3) begin
                            blk_done_q <= chk_ok_q;
                            ff_cnt_q   <= '0;
                            state_q    <= S_SYNC;
                        end else begin
                            wr_sel_q <= wr_sel_q + 2'd1;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_addr_o   = ram_addr_q;
    assign ram_do_o     = ram_do_q;
    assign ram_we_o     = ram_we_q;
    assign ram_sector_o = ram_sector_q;
    assign blk_done_o   = blk_done_q;
    assign blk_err_o    = blk_err_q;
    assign busy_o       = (state_q == S_ID) || (state_q == S_DATA)
                       || (state_q == S_CHK) || (state_q == S_TAIL);

endmodule

// File: tb/tb_c1541_gcr_write.sv
// Directed bench for c1541_gcr_write: data blocks, bad checksum, header skip,
// corrupt quintet, mode abort, reset mid-block, weak sync and bad sector.
// All payloads are payload[i]=i, so every write must carry data == address.
module tb_c1541_gcr_write;

    logic       clk_c1541 = 1'b0;
    logic       reset;
    logic       mtr_i, mode_i;
    logic [7:0] gcr_di_i;
    logic       byte_stb_i;
    logic [4:0] cur_sector_i;
    logic       ram_ready_i;
    logic [7:0] ram_addr_o, ram_do_o;
    logic       ram_we_o;
    logic [4:0] ram_sector_o;
    logic       blk_done_o, blk_err_o, busy_o;

    c1541_gcr_write dut (
        .clk_c1541   (clk_c1541),
        .reset       (reset),
        .mtr_i       (mtr_i),
        .mode_i      (mode_i),
        .gcr_di_i    (gcr_di_i),
        .byte_stb_i  (byte_stb_i),
        .cur_sector_i(cur_sector_i),
        .ram_ready_i (ram_ready_i),
        .ram_addr_o  (ram_addr_o),
        .ram_do_o    (ram_do_o),
        .ram_we_o    (ram_we_o),
        .ram_sector_o(ram_sector_o),
        .blk_done_o  (blk_done_o),
        .blk_err_o   (blk_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_c1541 = ~clk_c1541;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int wr_cnt = 0, addr_sum = 0, bad_dat = 0, last_addr = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;

    always @(negedge clk_c1541) begin
        if (ram_we_o) begin
            wr_cnt++;
            addr_sum += int'(ram_addr_o);
            last_addr = int'(ram_addr_o);
            if (ram_do_o != ram_addr_o) bad_dat++;
        end
        if (blk_done_o) done_cnt++;
        if (blk_err_o) err_cnt++;
        if (blk_done_o && blk_err_o) both_cnt++;
    end

    int b_wr, b_sum, b_bad, b_done, b_err;

    task automatic snap();
        b_wr = wr_cnt; b_sum = addr_sum; b_bad = bad_dat; b_done = done_cnt; b_err = err_cnt;
    endtask

    function automatic logic [4:0] enc5(input logic [3:0] n);
        case (n)
            4'h0: enc5 = 5'h0A; 4'h1: enc5 = 5'h0B; 4'h2: enc5 = 5'h12; 4'h3: enc5 = 5'h13;
            4'h4: enc5 = 5'h0E; 4'h5: enc5 = 5'h0F; 4'h6: enc5 = 5'h16; 4'h7: enc5 = 5'h17;
            4'h8: enc5 = 5'h09; 4'h9: enc5 = 5'h19; 4'hA: enc5 = 5'h1A; 4'hB: enc5 = 5'h1B;
            4'hC: enc5 = 5'h0D; 4'hD: enc5 = 5'h1D; 4'hE: enc5 = 5'h1E; default: enc5 = 5'h15;
        endcase
    endfunction

    function automatic logic [39:0] enc_grp(input logic [7:0] a, b, c, d);
        return {enc5(a[7:4]), enc5(a[3:0]), enc5(b[7:4]), enc5(b[3:0]),
                enc5(c[7:4]), enc5(c[3:0]), enc5(d[7:4]), enc5(d[3:0])};
    endfunction

    // Data block byte k: $07, payload 0..255, checksum, two off bytes.
    function automatic logic [7:0] blk_byte(input int k, input logic [7:0] ck);
        if (k == 0) return 8'h07;
        else if (k <= 256) return 8'(k - 1);
        else if (k == 257) return ck;
        else return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_c1541);
        gcr_di_i = b; byte_stb_i = 1'b1;
        @(negedge clk_c1541);
        byte_stb_i = 1'b0;
        repeat (16) @(negedge clk_c1541);
    endtask

    // 5th byte of group 0: first write must appear exactly 2 clk after the strobe.
    task automatic send_byte_lat(input logic [7:0] b);
        @(negedge clk_c1541);
        gcr_di_i = b; byte_stb_i = 1'b1;
        @(negedge clk_c1541);
        byte_stb_i = 1'b0;
        check("lat_cyc1_we", 32'(ram_we_o), 32'd0);
        @(negedge clk_c1541);
        check("lat_cyc2_we", 32'(ram_we_o), 32'd1);
        check("lat_cyc2_addr", 32'(ram_addr_o), 32'd0);
        check("lat_cyc2_do", 32'(ram_do_o), 32'd0);
        repeat (15) @(negedge clk_c1541);
    endtask

    task automatic send_grp(input logic [39:0] g);
        for (int j = 0; j < 5; j++) send_byte(g[39-8*j -: 8]);
    endtask

    task automatic send_data_block(input logic [7:0] ck, input int bad_grp, input int last_grp, input bit lat);
        logic [39:0] g;
        logic [7:0]  b;
        repeat (5) send_byte(8'hFF);
        for (int gi = 0; gi <= last_grp; gi++) begin
            g = enc_grp(blk_byte(4*gi, ck), blk_byte(4*gi+1, ck), blk_byte(4*gi+2, ck), blk_byte(4*gi+3, ck));
            for (int j = 0; j < 5; j++) begin
                b = g[39-8*j -: 8];
                if (gi == bad_grp && j == 0) b = 8'h00;
                if (lat && gi == 0 && j == 4) send_byte_lat(b);
                else send_byte(b);
            end
        end
    endtask

    initial begin
        reset = 1'b1; mtr_i = 1'b1; mode_i = 1'b0; gcr_di_i = 8'h00; byte_stb_i = 1'b0;
        cur_sector_i = 5'd5; ram_ready_i = 1'b1;
        repeat (3) @(negedge clk_c1541);
        check("rst_we", 32'(ram_we_o), 32'd0);
        check("rst_addr", 32'(ram_addr_o), 32'd0);
        check("rst_done", 32'(blk_done_o), 32'd0);
        check("rst_err", 32'(blk_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk_c1541);

        // 1) good block, sector 5
        snap();
        send_data_block(8'h00, -1, 64, 1'b1);
        check("t1_writes", 32'(wr_cnt - b_wr), 32'd256);
        check("t1_addr_sum", 32'(addr_sum - b_sum), 32'd32640);
        check("t1_data_eq_addr", 32'(bad_dat - b_bad), 32'd0);
        check("t1_last_addr", 32'(last_addr), 32'd255);
        check("t1_sector", 32'(ram_sector_o), 32'd5);
        check("t1_done", 32'(done_cnt - b_done), 32'd1);
        check("t1_err", 32'(err_cnt - b_err), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd0);

        // 2) bad checksum byte
        snap();
        send_data_block(8'h01, -1, 64, 1'b0);
        check("t2_writes", 32'(wr_cnt - b_wr), 32'd256);
        check("t2_done", 32'(done_cnt - b_done), 32'd0);
        check("t2_err", 32'(err_cnt - b_err), 32'd1);

        // 3) header block, ID $08
        snap();
        repeat (5) send_byte(8'hFF);
        send_grp(enc_grp(8'h08, 8'h00, 8'h00, 8'h01));
        send_grp(enc_grp(8'h00, 8'h00, 8'h0F, 8'h0F));
        check("t3_writes", 32'(wr_cnt - b_wr), 32'd0);
        check("t3_done", 32'(done_cnt - b_done), 32'd0);
        check("t3_err", 32'(err_cnt - b_err), 32'd0);
        check("t3_busy", 32'(busy_o), 32'd0);

        // 4) corrupt quintet in group 10, then a clean block
        snap();
        send_data_block(8'h00, 10, 64, 1'b0);
        check("t4_writes", 32'(wr_cnt - b_wr), 32'd39);
        check("t4_last_addr", 32'(last_addr), 32'd38);
        check("t4_addr_sum", 32'(addr_sum - b_sum), 32'd741);
        check("t4_err", 32'(err_cnt - b_err), 32'd1);
        check("t4_done", 32'(done_cnt - b_done), 32'd0);
        snap();
        send_data_block(8'h00, -1, 64, 1'b0);
        check("t4b_writes", 32'(wr_cnt - b_wr), 32'd256);
        check("t4b_data_eq_addr", 32'(bad_dat - b_bad), 32'd0);
        check("t4b_done", 32'(done_cnt - b_done), 32'd1);
        check("t4b_err", 32'(err_cnt - b_err), 32'd0);

        // 5) mode -> read around payload byte 100, then reset mid-DATA
        snap();
        send_data_block(8'h00, -1, 24, 1'b0);
        check("t5_writes", 32'(wr_cnt - b_wr), 32'd99);
        check("t5_busy_data", 32'(busy_o), 32'd1);
        mode_i = 1'b1;
        repeat (3) @(negedge clk_c1541);
        check("t5_mode_err", 32'(err_cnt - b_err), 32'd1);
        check("t5_mode_busy", 32'(busy_o), 32'd0);
        mode_i = 1'b0;
        repeat (3) @(negedge clk_c1541);
        send_data_block(8'h00, -1, 10, 1'b0);
        check("t5r_busy_before", 32'(busy_o), 32'd1);
        reset = 1'b1;
        @(negedge clk_c1541);
        check("t5r_we", 32'(ram_we_o), 32'd0);
        check("t5r_addr", 32'(ram_addr_o), 32'd0);
        check("t5r_do", 32'(ram_do_o), 32'd0);
        check("t5r_sector", 32'(ram_sector_o), 32'd0);
        check("t5r_busy", 32'(busy_o), 32'd0);
        check("t5r_pulses", 32'({blk_done_o, blk_err_o}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk_c1541);

        // 6) single $FF is not enough sync; then an out-of-range sector
        snap();
        send_byte(8'hFF);
        send_grp(enc_grp(8'h07, 8'h00, 8'h01, 8'h02));
        check("t6_weak_writes", 32'(wr_cnt - b_wr), 32'd0);
        check("t6_weak_busy", 32'(busy_o), 32'd0);
        check("t6_weak_err", 32'(err_cnt - b_err), 32'd0);
        cur_sector_i = 5'd21;
        snap();
        send_data_block(8'h00, -1, 64, 1'b0);
        check("t6_sec_writes", 32'(wr_cnt - b_wr), 32'd0);
        check("t6_sec_err", 32'(err_cnt - b_err), 32'd1);
        check("t6_sec_done", 32'(done_cnt - b_done), 32'd0);

        check("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
